// File: rtl/pc_ctrl.sv
// Program-counter unit: boot delay, fetch handshake, stall, redirect,
// halt/resume, exception entry with EPC capture and eret return.
module pc_ctrl #(
  parameter int          AW        = 32,
  parameter logic [31:0] RESET_VEC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
  parameter int          BOOT_WAIT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:2] npc,
  input  logic          fetch_ready,
  input  logic          stall,
  input  logic          redirect,
  input  logic [AW-1:2] redirect_pc,
  input  logic          exc,
  input  logic          eret,
  input  logic          halt,
  input  logic          resume,
  output logic [AW-1:2] pc,
  output logic          pc_valid,
  output logic [AW-1:2] epc,
  output logic          in_exc,
  output logic [1:0]    dbg_state
);

  // Handshake: pc is a fetch address only while pc_valid=1; imem takes it
  // in any cycle where fetch_ready=1, and the pc then advances to npc
  // unless stalled or overridden by a higher-priority event.

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [AW-1:2] RST_PC    = RESET_VEC[AW-1:2];
  localparam logic [AW-1:2] EXC_PC    = EXC_VEC[AW-1:2];
  localparam logic [3:0]    BOOT_LAST = 4'(BOOT_WAIT - 1);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:2] pc_q, pc_d;
  logic [AW-1:2] epc_q, epc_d;
  logic          in_exc_q, in_exc_d;
  logic          valid_q, valid_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_BOOT;
      cnt_q    <= 4'd0;
      pc_q     <= RST_PC;
      epc_q    <= '0;
      in_exc_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pc_q     <= pc_d;
      epc_q    <= epc_d;
      in_exc_q <= in_exc_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pc_d     = pc_q;
    epc_d    = epc_q;
    in_exc_d = in_exc_q;
    case (state_q)
      ST_BOOT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == BOOT_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (exc) begin
          pc_d = EXC_PC;
          // A nested exception keeps the EPC of the outermost one.
          if (!in_exc_q) begin
            epc_d    = pc_q;
            in_exc_d = 1'b1;
          end
        end else if (eret && in_exc_q) begin
          pc_d     = epc_q;
          in_exc_d = 1'b0;
        end else if (redirect) begin
          pc_d = redirect_pc;
        end else if (halt) begin
          state_d = ST_HALT;
        end else if (fetch_ready && !stall) begin
          pc_d = npc;
        end
      end
      ST_HALT: begin
        if (exc) begin
          pc_d    = EXC_PC;
          state_d = ST_RUN;
          if (!in_exc_q) begin
            epc_d    = pc_q;
            in_exc_d = 1'b1;
          end
        end else if (resume) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
    valid_d = (state_d == ST_RUN);
  end

  assign pc        = pc_q;
  assign pc_valid  = valid_q;
  assign epc       = epc_q;
  assign in_exc    = in_exc_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Bench for pc_ctrl: directed scenarios plus randomized traffic scored
// against a behavioural model through an expected-value queue.
module tb_pc_ctrl;

  localparam int W = 62;  // {pc_valid, in_exc, epc[29:0], pc[29:0]}
  localparam logic [31:0] RV = 32'h0000_3000;
  localparam logic [31:0] EV = 32'h0000_4180;
  localparam logic [29:0] M_RST_PC = 30'(RV >> 2);
  localparam logic [29:0] M_EXC_PC = 30'(EV >> 2);
  localparam int BOOT_CYCLES = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic [29:0] npc = '0, redirect_pc = '0;
  logic        fetch_ready = 0, stall = 0, redirect = 0, exc = 0, eret = 0, halt = 0, resume = 0;
  logic [29:0] pc, epc;
  logic        pc_valid, in_exc;
  logic [1:0]  dbg_state;

  pc_ctrl dut (
    .clk(clk), .rst(rst), .npc(npc), .fetch_ready(fetch_ready), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .exc(exc), .eret(eret),
    .halt(halt), .resume(resume), .pc(pc), .pc_valid(pc_valid), .epc(epc),
    .in_exc(in_exc), .dbg_state(dbg_state)
  );

  // Narrow-address instance: low vector bits must be dropped.
  logic        b_rst = 1'b0, b_redirect = 1'b0;
  logic [13:0] b_redirect_pc = '0;
  logic [13:0] b_pc, b_epc;
  logic        b_pc_valid, b_in_exc;
  logic [1:0]  b_dbg_state;

  pc_ctrl #(.AW(16), .RESET_VEC(32'h0000_0102), .EXC_VEC(32'h0000_4180), .BOOT_WAIT(2)) dut16 (
    .clk(clk), .rst(b_rst), .npc(14'h0), .fetch_ready(1'b0), .stall(1'b0),
    .redirect(b_redirect), .redirect_pc(b_redirect_pc), .exc(1'b0), .eret(1'b0),
    .halt(1'b0), .resume(1'b0), .pc(b_pc), .pc_valid(b_pc_valid), .epc(b_epc),
    .in_exc(b_in_exc), .dbg_state(b_dbg_state)
  );

  // ---------------- reference model ----------------
  // mode: 0 booting, 1 running, 2 halted
  int          m_mode;
  int          m_boot_seen;
  logic [29:0] m_pc, m_epc;
  logic        m_in_exc;

  task automatic model_reset();
    m_mode = 0; m_boot_seen = 0;
    m_pc = M_RST_PC; m_epc = '0; m_in_exc = 1'b0;
  endtask

  task automatic model_enter_exc();
    if (!m_in_exc) begin
      m_epc = m_pc;
      m_in_exc = 1'b1;
    end
    m_pc = M_EXC_PC;
  endtask

  task automatic model_edge();
    if (!rst) begin
      model_reset();
    end else if (m_mode == 0) begin
      m_boot_seen++;
      if (m_boot_seen >= BOOT_CYCLES) m_mode = 1;
    end else if (m_mode == 1) begin
      if (exc) model_enter_exc();
      else if (eret && m_in_exc) begin m_pc = m_epc; m_in_exc = 1'b0; end
      else if (redirect) m_pc = redirect_pc;
      else if (halt) m_mode = 2;
      else if (fetch_ready && !stall) m_pc = npc;
    end else begin
      if (exc) begin model_enter_exc(); m_mode = 1; end
      else if (resume) m_mode = 1;
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e, a;
      e = exp_q.pop_front();
      a = {pc_valid, in_exc, epc, pc};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL scoreboard: got valid=%0b in_exc=%0b epc=0x%0h pc=0x%0h expected valid=%0b in_exc=%0b epc=0x%0h pc=0x%0h at %0t",
                 a[61], a[60], a[59:30], a[29:0], e[61], e[60], e[59:30], e[29:0], $time);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    model_edge();
    exp_q.push_back({(m_mode == 1) ? 1'b1 : 1'b0, m_in_exc, m_epc, m_pc});
    #1;
  endtask

  task automatic idle_inputs();
    fetch_ready = 0; stall = 0; redirect = 0; exc = 0; eret = 0; halt = 0; resume = 0;
  endtask

  task automatic mid_cycle_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("async_rst_pc", {2'b0, pc}, {2'b0, M_RST_PC});
    chk("async_rst_epc", {2'b0, epc}, 32'h0);
    chk("async_rst_in_exc", {31'b0, in_exc}, 32'h0);
    chk("async_rst_valid", {31'b0, pc_valid}, 32'h0);
    step();
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    step(); step();
    chk("reset_pc", {2'b0, pc}, 32'h0000_0C00);
    chk("reset_valid", {31'b0, pc_valid}, 32'h0);
    chk("w16_reset_pc", {18'b0, b_pc}, 32'h0000_0040);

    // T1: boot delay
    rst = 1'b1; b_rst = 1'b1;
    step();
    chk("boot_valid_edge1", {31'b0, pc_valid}, 32'h0);
    step();
    chk("boot_valid_edge2", {31'b0, pc_valid}, 32'h1);
    chk("boot_pc", {2'b0, pc}, 32'h0000_0C00);

    // T2: sequential fetch then hold
    fetch_ready = 1;
    for (int i = 0; i < 4; i++) begin
      npc = m_pc + 30'd1;
      step();
    end
    chk("seq_pc", {2'b0, pc}, 32'h0000_0C04);
    npc = m_pc + 30'd1; stall = 1;
    step(); step();
    stall = 0; fetch_ready = 0;
    step(); step();
    chk("hold_pc", {2'b0, pc}, 32'h0000_0C04);

    // T3: exception priority, nesting, eret
    redirect = 1; redirect_pc = 30'hC02;
    step();
    exc = 1; eret = 1; redirect_pc = 30'hD00;
    step();
    chk("exc_pc", {2'b0, pc}, 32'h0000_1060);
    chk("exc_epc", {2'b0, epc}, 32'h0000_0C02);
    chk("exc_in_exc", {31'b0, in_exc}, 32'h1);
    redirect = 0; eret = 0;
    step();
    chk("nested_epc", {2'b0, epc}, 32'h0000_0C02);
    exc = 0; eret = 1;
    step();
    chk("eret_pc", {2'b0, pc}, 32'h0000_0C02);
    chk("eret_in_exc", {31'b0, in_exc}, 32'h0);
    redirect = 1; redirect_pc = 30'hD00;
    step();
    chk("eret_ignored_redirect", {2'b0, pc}, 32'h0000_0D00);

    // T4: halt / resume / exc out of halt
    idle_inputs(); halt = 1;
    step();
    halt = 0;
    for (int i = 0; i < 3; i++) begin
      npc = 30'($urandom); redirect = i[0]; redirect_pc = 30'($urandom); stall = ~i[0];
      fetch_ready = 1; eret = 1;
      step();
    end
    chk("halt_pc", {2'b0, pc}, 32'h0000_0D00);
    chk("halt_valid", {31'b0, pc_valid}, 32'h0);
    idle_inputs(); resume = 1;
    step();
    chk("resume_valid", {31'b0, pc_valid}, 32'h1);
    resume = 0; halt = 1;
    step();
    halt = 0; exc = 1;
    step();
    chk("halt_exc_pc", {2'b0, pc}, 32'h0000_1060);
    chk("halt_exc_valid", {31'b0, pc_valid}, 32'h1);
    exc = 0;
    step();

    // T5: asynchronous reset while inside the handler
    mid_cycle_reset();
    step(); step();

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        idle_inputs();
        mid_cycle_reset();
      end else begin
        exc         = ($urandom_range(0, 99) < 5);
        eret        = ($urandom_range(0, 99) < 10);
        redirect    = ($urandom_range(0, 99) < 10);
        halt        = ($urandom_range(0, 99) < 5);
        resume      = ($urandom_range(0, 99) < 25);
        stall       = ($urandom_range(0, 99) < 30);
        fetch_ready = ($urandom_range(0, 99) < 70);
        npc         = ($urandom_range(0, 3) != 0) ? m_pc + 30'd1 : 30'($urandom);
        redirect_pc = 30'($urandom);
        step();
      end
    end
    idle_inputs();

    // T6: narrow address width
    chk("w16_run_pc", {18'b0, b_pc}, 32'h0000_0040);
    chk("w16_valid", {31'b0, b_pc_valid}, 32'h1);
    b_redirect = 1; b_redirect_pc = 14'h3FFF;
    step();
    b_redirect = 0;
    chk("w16_redirect_pc", {18'b0, b_pc}, 32'h0000_3FFF);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
